// File: rtl/ysyx_23060221_ifu.sv
// Instruction fetch stage: holds the PC and issues one AXI-lite read per instruction.
// It hands inst/pc to decode, then waits for the write-back npc before fetching again.
module ysyx_23060221_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [15:0] TIMEOUT  = 16'd1024
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        inst_fault,
   output logic        IFU_valid,
   input  logic        IDU_ready,
   input  logic [31:0] npc,
   input  logic        npc_valid,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [1:0] {
      S_REQ,
      S_RESP,
      S_OUT,
      S_PC
   } state_t;

   state_t      state, state_n;
   logic [31:0] pc_n, inst_n, cnt_n;
   logic        fault_n;
   logic [15:0] timer, timer_n;
   logic        misalign;

   assign misalign  = pc[1:0] != 2'b00;
   assign araddr    = pc;
   assign arvalid   = (state == S_REQ) && !rst && !misalign;
   assign rready    = (state == S_RESP) && !rst;
   assign IFU_valid = (state == S_OUT) && !rst;

   always_comb begin
      state_n = state;
      pc_n    = pc;
      inst_n  = inst;
      fault_n = inst_fault;
      cnt_n   = fetch_cnt;
      timer_n = timer;
      unique case (state)
         S_REQ: begin
            // A misaligned pc never reaches the bus; it is reported as a fault.
            if (misalign) begin
               inst_n  = 32'd0;
               fault_n = 1'b1;
               state_n = S_OUT;
            end else if (arready) begin
               timer_n = 16'd0;
               state_n = S_RESP;
            end
         end
         S_RESP: begin
            if (rvalid) begin
               inst_n  = rdata;
               fault_n = rresp != 2'b00;
               state_n = S_OUT;
            end else if (timer == TIMEOUT - 16'd1) begin
               inst_n  = 32'd0;
               fault_n = 1'b1;
               state_n = S_OUT;
            end else begin
               timer_n = timer + 16'd1;
            end
         end
         S_OUT: begin
            if (IDU_ready) begin
               cnt_n   = fetch_cnt + 32'd1;
               state_n = S_PC;
            end
         end
         S_PC: begin
            if (npc_valid) begin
               pc_n    = npc;
               state_n = S_REQ;
            end
         end
         default: state_n = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_REQ;
         pc         <= RESET_PC;
         inst       <= 32'd0;
         inst_fault <= 1'b0;
         fetch_cnt  <= 32'd0;
         timer      <= 16'd0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         inst       <= inst_n;
         inst_fault <= fault_n;
         fetch_cnt  <= cnt_n;
         timer      <= timer_n;
      end
   end

endmodule

// File: tb/tb_ysyx_23060221_ifu.sv
// Randomized bench for the fetch stage: a driver plays memory, decode and write-back,
// and a negedge monitor checks every bus request and decode output against a queue.
module tb_ysyx_23060221_ifu;

   localparam logic [31:0] RPC = 32'h8000_0000;
   localparam int          TO  = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_fault;
   logic        IFU_valid;
   logic        IDU_ready;
   logic [31:0] npc;
   logic        npc_valid;
   logic [31:0] fetch_cnt;

   always #5 clk = ~clk;

   ysyx_23060221_ifu #(
      .RESET_PC(RPC),
      .TIMEOUT (16'(TO))
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .araddr    (araddr),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rresp     (rresp),
      .rvalid    (rvalid),
      .rready    (rready),
      .inst      (inst),
      .pc        (pc),
      .inst_fault(inst_fault),
      .IFU_valid (IFU_valid),
      .IDU_ready (IDU_ready),
      .npc       (npc),
      .npc_valid (npc_valid),
      .fetch_cnt (fetch_cnt)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] addr_q[$];
   int          pass = 0;
   int          total = 0;
   logic [31:0] cnt_model = 32'd0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == RPC) return 32'h0000_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act === req) pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, req);
   endtask

   // Expected decode output per fetch, from the fetch rules alone.
   // mode 0 = OKAY, 1 = error response, 2 = no response (timeout).
   task automatic push_exp(input logic [31:0] a, input int mode);
      exp_t e;
      e.pc = a;
      if (a[1:0] != 2'b00) begin
         e.inst  = 32'd0;
         e.fault = 1'b1;
      end else begin
         e.inst  = (mode == 2) ? 32'd0 : mem(a);
         e.fault = (mode != 0);
         addr_q.push_back(a);
      end
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (arvalid) begin
            if (addr_q.size() == 0) chk("spurious_arvalid", 32'd1, 32'd0);
            else begin
               chk("araddr", araddr, addr_q[0]);
               if (arready) void'(addr_q.pop_front());
            end
         end
         if (IFU_valid) begin
            if (exp_q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
            else begin
               chk("pc", pc, exp_q[0].pc);
               chk("inst", inst, exp_q[0].inst);
               chk("fault", {31'd0, inst_fault}, {31'd0, exp_q[0].fault});
               if (IDU_ready) begin
                  chk("fetch_cnt", fetch_cnt, cnt_model);
                  cnt_model++;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic handshake(input int k);
      bit ok = 1'b0;
      arready = 1'b0;
      repeat (k) @(posedge clk);
      #1 arready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (arvalid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("ar_wait", 32'd0, 32'd1);
      @(posedge clk);
      #1 arready = 1'b0;
   endtask

   task automatic out_phase(input int r);
      bit ok = 1'b0;
      IDU_ready = 1'b0;
      for (int i = 0; i < r; i++) begin
         @(posedge clk);
         #1 npc_valid = 1'($urandom % 2);
         npc = $urandom;
      end
      IDU_ready = 1'b1;
      npc_valid = 1'($urandom % 2);
      npc = $urandom;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (IFU_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("out_wait", 32'd0, 32'd1);
      @(posedge clk);
      #1 IDU_ready = 1'b0;
      npc_valid = 1'b0;
   endtask

   task automatic fetch_body(input logic [31:0] a, input int mode,
                             input int k, input int d, input int r);
      int n;
      if (a[1:0] == 2'b00) begin
         handshake(k);
         if (mode == 2) begin
            rvalid = 1'b0;
            n = 0;
            for (int i = 0; i < 64; i++) begin
               @(negedge clk);
               if (IFU_valid) break;
               n++;
            end
            chk("timeout_cycles", 32'(n), 32'(TO));
            rvalid = 1'b1;
            rdata  = $urandom;
            rresp  = 2'b00;
            @(posedge clk);
            #1 rvalid = 1'b0;
         end else begin
            repeat (d) @(posedge clk);
            #1 rvalid = 1'b1;
            rdata  = mem(a);
            rresp  = (mode == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
            @(posedge clk);
            #1 rvalid = 1'b0;
            rresp  = 2'b00;
         end
      end
      out_phase(r);
   endtask

   task automatic reset_mid(input logic [31:0] a);
      handshake(1);
      rst    = 1'b1;
      rvalid = 1'b1;
      rdata  = $urandom;
      @(posedge clk);
      #1 exp_q.delete();
      addr_q.delete();
      cnt_model = 32'd0;
      @(negedge clk);
      chk("rst_pc", pc, RPC);
      chk("rst_valid", {31'd0, IFU_valid}, 32'd0);
      chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
      chk("rst_cnt", fetch_cnt, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      push_exp(RPC, 0);
      @(posedge clk);
      #1 rvalid = 1'b0;
      fetch_body(RPC, 0, 0, 0, 1);
      if (a == 32'd0) chk("rst_addr", a, 32'd1);
   endtask

   initial begin
      logic [31:0] nxt;
      int          mode;
      rst = 1'b1;
      arready = 1'b0;
      rdata = 32'd0;
      rresp = 2'b00;
      rvalid = 1'b0;
      IDU_ready = 1'b0;
      npc = 32'd0;
      npc_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_arvalid", {31'd0, arvalid}, 32'd0);
      chk("reset_rready", {31'd0, rready}, 32'd0);
      chk("reset_valid", {31'd0, IFU_valid}, 32'd0);
      chk("reset_pc", pc, RPC);
      chk("reset_inst", inst, 32'd0);
      chk("reset_fault", {31'd0, inst_fault}, 32'd0);
      chk("reset_cnt", fetch_cnt, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      push_exp(RPC, 0);
      fetch_body(RPC, 0, 0, 0, 5);
      for (int t = 0; t < 70; t++) begin
         mode = $urandom % 6;
         mode = (mode < 4) ? 0 : mode - 3;
         nxt  = {16'h8000, 16'($urandom)};
         if ($urandom % 6 != 0 || t == 30) nxt[1:0] = 2'b00;
         else if (nxt[1:0] == 2'b00) nxt[1:0] = 2'b10;
         if (t == 30) mode = 0;
         repeat ($urandom % 3) @(posedge clk);
         #1 npc = nxt;
         npc_valid = 1'b1;
         if (t != 30) push_exp(nxt, mode);
         else addr_q.push_back(nxt);
         @(posedge clk);
         #1 npc_valid = 1'b0;
         if (t == 30) reset_mid(nxt);
         else fetch_body(nxt, mode, $urandom % 3, $urandom % 5, $urandom % 5);
      end
      repeat (3) @(posedge clk);
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      chk("addr_q_empty", 32'(addr_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
